fifo_buffer_out_param: RTL and testbench

Next-generation output-data FIFO for the MAC datapath, replacing the fixed 4-entry output buffer. Depth and width are parametrised, and full/occupancy logic is generic rather than hard-wired to 4 slots. The block adds empty, almost-full, an occupancy count, sticky overflow/underflow error flags and defined simultaneous push/pop behaviour. It sits between the MAC result stage (push side) and the downstream consumer (pop side).

---
 rtl/fifo_buffer_out_param_pkg.sv | 27 ++
 rtl/fifo_ptr_wrap.sv | 30 +++
 rtl/fifo_buffer_out_param.sv | 105 ++++++++++
 tb/tb_fifo_buffer_out_param.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fifo_buffer_out_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_buffer_out_param_pkg
// Brief    : Default geometry and the depth/address-width consistency helpers
// Revision : 1.0  initial release
// ============================================================================
package fifo_buffer_out_param_pkg;

    localparam int c_DEF_DATA_WIDTH   = 32;
    localparam int c_DEF_BUFFER_WIDTH = 2;
    localparam int c_DEF_BUFFER_SIZE  = 4;
    localparam int c_DEF_AF_THR       = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Depth must be an exact power of two that matches the address width.
    function automatic bit geometry_ok(input int buf_width, input int buf_size);
        return (buf_size == (1 << buf_width)) && (clog2(buf_size) == buf_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_wrap.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_wrap
// Brief    : Wrap-bit FIFO pointer with increment enable, async active-low reset
// Revision : 1.0  initial release
// ============================================================================
module fifo_ptr_wrap #(
    parameter int PTR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    output logic [PTR_WIDTH-1:0] o_ptr
);

    logic [PTR_WIDTH-1:0] r_ptr;

    // MSB toggles on each lap, distinguishing full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_buffer_out_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_buffer_out_param
// Brief    : Parametrised FWFT output FIFO with occupancy, slot map, error flags
// Revision : 1.0  initial release
// ============================================================================
module fifo_buffer_out_param
    import fifo_buffer_out_param_pkg::*;
#(
    parameter int DATA_WIDTH      = c_DEF_DATA_WIDTH,
    parameter int BUFFER_WIDTH    = c_DEF_BUFFER_WIDTH,
    parameter int BUFFER_SIZE     = c_DEF_BUFFER_SIZE,
    parameter int ALMOST_FULL_THR = c_DEF_AF_THR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Push,
    input  logic                    Pop,
    input  logic                    ClrErr,
    input  logic [DATA_WIDTH-1:0]   DataIn,
    output logic [DATA_WIDTH-1:0]   DataOut,
    output logic                    Full,
    output logic                    Empty,
    output logic                    AlmostFull,
    output logic [BUFFER_WIDTH:0]   Count,
    output logic [BUFFER_SIZE-1:0]  SlotValid,
    output logic                    Overflow,
    output logic                    Underflow
);

    generate
        if (!geometry_ok(BUFFER_WIDTH, BUFFER_SIZE)) begin : g_bad_geometry
            $error("BUFFER_SIZE must equal 2**BUFFER_WIDTH");
        end
    endgenerate

    logic [BUFFER_WIDTH:0]   w_wr_ptr;
    logic [BUFFER_WIDTH:0]   w_rd_ptr;
    logic [BUFFER_WIDTH:0]   w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push_ok;
    logic                    w_pop_ok;
    logic [DATA_WIDTH-1:0]   r_mem [BUFFER_SIZE];
    logic                    r_overflow;
    logic                    r_underflow;

    assign w_full  = (w_wr_ptr[BUFFER_WIDTH-1:0] == w_rd_ptr[BUFFER_WIDTH-1:0]) &&
                     (w_wr_ptr[BUFFER_WIDTH] != w_rd_ptr[BUFFER_WIDTH]);
    assign w_empty = (w_wr_ptr == w_rd_ptr);
    assign w_count = w_wr_ptr - w_rd_ptr;

    // A pop frees the head slot, so a push into a full queue is legal alongside it.
    assign w_push_ok = Push & (~w_full | Pop);
    assign w_pop_ok  = Pop & ~w_empty;

    fifo_ptr_wrap #(.PTR_WIDTH(BUFFER_WIDTH + 1)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push_ok),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr_wrap #(.PTR_WIDTH(BUFFER_WIDTH + 1)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pop_ok),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_ptr[BUFFER_WIDTH-1:0]] <= DataIn;
        end
    end

    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (Push & ~w_push_ok) | (r_overflow  & ~ClrErr);
            r_underflow <= (Pop  & w_empty)    | (r_underflow & ~ClrErr);
        end
    end

    generate
        for (genvar gi = 0; gi < BUFFER_SIZE; gi++) begin : g_slot
            logic [BUFFER_WIDTH-1:0] w_offset;
            assign w_offset      = BUFFER_WIDTH'(gi) - w_rd_ptr[BUFFER_WIDTH-1:0];
            assign SlotValid[gi] = ({1'b0, w_offset} < w_count);
        end
    endgenerate

    assign DataOut    = r_mem[w_rd_ptr[BUFFER_WIDTH-1:0]];
    assign Full       = w_full;
    assign Empty      = w_empty;
    assign AlmostFull = (w_count >= (BUFFER_WIDTH + 1)'(ALMOST_FULL_THR));
    assign Count      = w_count;
    assign Overflow   = r_overflow;
    assign Underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_buffer_out_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_buffer_out_param
// Brief    : Directed and random checks against a queue-based reference model
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_buffer_out_param;

    localparam int c_DEPTH = 4;
    localparam int c_AF    = 3;

    logic        clk;
    logic        rst;
    logic        Push, Pop, ClrErr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Full, Empty, AlmostFull;
    logic [2:0]  Count;
    logic [3:0]  SlotValid;
    logic        Overflow, Underflow;

    int          checks;
    int          errors;

    logic [31:0] m_q[$];
    bit   [3:0]  m_vld;
    int          m_wslot, m_rslot;
    bit          m_ovf, m_unf;

    fifo_buffer_out_param dut (
        .clk        (clk),
        .rst        (rst),
        .Push       (Push),
        .Pop        (Pop),
        .ClrErr     (ClrErr),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .Full       (Full),
        .Empty      (Empty),
        .AlmostFull (AlmostFull),
        .Count      (Count),
        .SlotValid  (SlotValid),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".Count"},      32'(Count),      32'(m_q.size()));
        check({ctx, ".Empty"},      32'(Empty),      32'(m_q.size() == 0));
        check({ctx, ".Full"},       32'(Full),       32'(m_q.size() == c_DEPTH));
        check({ctx, ".AlmostFull"}, 32'(AlmostFull), 32'(m_q.size() >= c_AF));
        check({ctx, ".SlotValid"},  32'(SlotValid),  32'(m_vld));
        check({ctx, ".Overflow"},   32'(Overflow),   32'(m_ovf));
        check({ctx, ".Underflow"},  32'(Underflow),  32'(m_unf));
        if (m_q.size() != 0) check({ctx, ".DataOut"}, DataOut, m_q[0]);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_vld   = '0;
        m_wslot = 0;
        m_rslot = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic step(input string ctx, input bit ps, input bit pp, input bit clr,
                        input logic [31:0] d);
        bit full, empty, push_ok, pop_ok;
        @(negedge clk);
        Push = ps; Pop = pp; ClrErr = clr; DataIn = d;
        full    = (m_q.size() == c_DEPTH);
        empty   = (m_q.size() == 0);
        push_ok = ps && (!full || pp);
        pop_ok  = pp && !empty;
        m_ovf   = (ps && !push_ok) || (m_ovf && !clr);
        m_unf   = (pp && empty)    || (m_unf && !clr);
        if (pop_ok) begin
            void'(m_q.pop_front());
            m_vld[m_rslot] = 1'b0;
            m_rslot = (m_rslot + 1) % c_DEPTH;
        end
        if (push_ok) begin
            m_q.push_back(d);
            m_vld[m_wslot] = 1'b1;
            m_wslot = (m_wslot + 1) % c_DEPTH;
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; Push = 1'b0; Pop = 1'b0; ClrErr = 1'b0; DataIn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        step("idle", 0, 0, 0, 0);

        // Fill to almost-full, DataOut falls through from first push
        step("pushA0", 1, 0, 0, 32'hA0);
        step("pushA1", 1, 0, 0, 32'hA1);
        step("pushA2", 1, 0, 0, 32'hA2);
        repeat (3) step("drainA", 0, 1, 0, 0);

        // Overflow and ordered drain
        for (int i = 0; i < 4; i++) step("fill10", 1, 0, 0, 32'h10 + 32'(i));
        step("push99_full", 1, 0, 0, 32'h99);
        repeat (4) step("pop10", 0, 1, 0, 0);
        step("clr_ovf", 0, 0, 1, 0);

        // Push+pop while full, write pointer wraps
        for (int i = 0; i < 4; i++) step("refill10", 1, 0, 0, 32'h10 + 32'(i));
        step("pushpop_full", 1, 1, 0, 32'h55);
        repeat (4) step("pop_wrap", 0, 1, 0, 0);

        // Pop+push while empty
        step("pushpop_empty", 1, 1, 0, 32'h77);
        step("clr_unf", 0, 0, 1, 0);
        step("pop77", 0, 1, 0, 0);

        // Slot map across the wrap
        step("p1", 1, 0, 0, 32'h1);
        step("p2", 1, 0, 0, 32'h2);
        step("pop1", 0, 1, 0, 0);
        step("p3", 1, 0, 0, 32'h3);
        step("p4", 1, 0, 0, 32'h4);
        step("p5", 1, 0, 0, 32'h5);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        Push = 1'b0; Pop = 1'b0; ClrErr = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 0, 0, 0, 0);

        // Clear coincident with a new error keeps the flag
        step("unf_set", 0, 1, 0, 0);
        step("unf_clr_collide", 0, 1, 1, 0);

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 10), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
